zxb_slave: RTL

ZXB_SLAVE -- requirements
Module: zxb_slave

---
 rtl/zxb_pkg.sv | 31 +++
 rtl/zxb_sram_if.sv | 111 +++++++++++
 rtl/zxb_slave.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/zxb_pkg.sv
// Shared definitions for the ZX bus slave: port offsets, CTRL bit layout and FSM state encodings.
package zxb_pkg;

    localparam logic [1:0] OFF_PAGE    = 2'd0;
    localparam logic [1:0] OFF_CTRL    = 2'd1;
    localparam logic [1:0] OFF_SCRATCH = 2'd2;
    localparam logic [1:0] OFF_ACCNT   = 2'd3;

    localparam int CTRL_MEN = 0;
    localparam int PAGE_W   = 5;

    typedef enum logic [2:0] {
        MS_IDLE   = 3'd0,
        MS_SETUP  = 3'd1,
        MS_WAIT   = 3'd2,
        MS_STROBE = 3'd3,
        MS_HOLD   = 3'd4
    } mem_state_t;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_STB  = 2'd1,
        PS_HOLD = 2'd2
    } port_state_t;

    // The page register selects a 16 KB window of the 512 KB SRAM.
    function automatic logic [18:0] sram_addr_f(input logic [PAGE_W-1:0] page, input logic [13:0] offset);
        return {page, offset};
    endfunction

endpackage

// File: rtl/zxb_sram_if.sv
// Memory access sequencer: SETUP / WAIT / STROBE / HOLD timing and registered SRAM pin drive.
module zxb_sram_if
    import zxb_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mem_req,
    input  logic        rnw,
    input  logic [7:0]  wdata,
    input  logic [18:0] addr,
    input  logic [7:0]  sram_dq_i,
    output logic        mem_stb,
    output logic        rd_done,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_cs_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    mem_state_t  state_r, state_next_s;
    logic [3:0]  wait_cnt_r;
    logic        rnw_r, rnw_eff_s;
    logic        active_next_s, we_next_s;
    logic [18:0] addr_r;
    logic [7:0]  dq_o_r;
    logic        stb_r, cs_n_r, oe_n_r, we_n_r, dq_oe_r;

    // Next-state logic and the pin levels that the next state will need.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            MS_IDLE: begin
                if (start) state_next_s = MS_SETUP;
                else       state_next_s = MS_IDLE;
            end
            MS_SETUP: begin
                if (MEM_WAIT > 0) state_next_s = MS_WAIT;
                else              state_next_s = MS_STROBE;
            end
            MS_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) state_next_s = MS_STROBE;
                else                         state_next_s = MS_WAIT;
            end
            MS_STROBE: state_next_s = MS_HOLD;
            MS_HOLD: begin
                if (!mem_req) state_next_s = MS_IDLE;
                else          state_next_s = MS_HOLD;
            end
            default: state_next_s = MS_IDLE;
        endcase

        if (state_r == MS_IDLE) rnw_eff_s = rnw;
        else                    rnw_eff_s = rnw_r;

        active_next_s = (state_next_s == MS_SETUP) || (state_next_s == MS_WAIT) ||
                        (state_next_s == MS_STROBE);
        // Write strobe releases one cycle early so data is held through STROBE.
        we_next_s = ((state_next_s == MS_SETUP) || (state_next_s == MS_WAIT)) && !rnw_eff_s;
    end

    // State, wait counter, access latches and registered SRAM pins.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= MS_IDLE;
            wait_cnt_r <= 4'd0;
            rnw_r      <= 1'b1;
            addr_r     <= 19'd0;
            dq_o_r     <= 8'd0;
            stb_r      <= 1'b0;
            cs_n_r     <= 1'b1;
            oe_n_r     <= 1'b1;
            we_n_r     <= 1'b1;
            dq_oe_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (state_r == MS_WAIT) wait_cnt_r <= wait_cnt_r + 4'd1;
            else                    wait_cnt_r <= 4'd0;
            if ((state_r == MS_IDLE) && start) begin
                rnw_r  <= rnw;
                addr_r <= addr;
                dq_o_r <= rnw ? 8'd0 : wdata;
            end else begin
                rnw_r  <= rnw_r;
                addr_r <= addr_r;
                dq_o_r <= dq_o_r;
            end
            stb_r   <= (state_next_s == MS_STROBE);
            cs_n_r  <= !active_next_s;
            oe_n_r  <= !(active_next_s && rnw_eff_s);
            we_n_r  <= !we_next_s;
            dq_oe_r <= active_next_s && !rnw_eff_s;
        end
    end

    assign mem_stb    = stb_r;
    assign rd_done    = (state_r == MS_STROBE) && rnw_r;
    assign sram_addr  = addr_r;
    assign sram_dq_o  = dq_o_r;
    assign sram_dq_oe = dq_oe_r;
    assign sram_cs_n  = cs_n_r;
    assign sram_oe_n  = oe_n_r;
    assign sram_we_n  = we_n_r;

endmodule

// File: rtl/zxb_slave.sv
// ZX bus slave: address decode, four-register port block, port handshake and paged SRAM window.
module zxb_slave
    import zxb_pkg::*;
#(
    parameter logic [7:0] PORT_BASE = 8'hF0,
    parameter logic [1:0] MEM_WIN   = 2'b11,
    parameter int         MEM_WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] zaddr,
    input  logic [7:0]  zdata_in,
    input  logic        zxb_rnw,
    input  logic        zxb_mni,
    output logic        zxb_en,
    input  logic        mem_req,
    output logic        mem_stb,
    input  logic        port_req,
    output logic        port_stb,
    output logic [7:0]  rdata,
    output logic [18:0] sram_addr,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    input  logic [7:0]  sram_dq_i,
    output logic        sram_cs_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    port_state_t       port_state_r, port_state_next_s;
    logic              port_stb_r, port_go_s, port_wr_s;
    logic              mem_hit_s, port_hit_s, mem_start_s, mem_rd_done_s;
    logic [PAGE_W-1:0] page_r;
    logic              ctrl_men_r;
    logic [7:0]        scratch_r, accnt_r, rdata_r, port_rd_s;

    assign mem_hit_s   = zxb_mni && ctrl_men_r && (zaddr[15:14] == MEM_WIN);
    assign port_hit_s  = !zxb_mni && (zaddr[7:2] == PORT_BASE[7:2]);
    assign zxb_en      = mem_hit_s || port_hit_s;
    assign mem_start_s = mem_req && mem_hit_s;

    // Port handshake: act once on the first request cycle, then wait for release.
    always_comb begin
        port_state_next_s = port_state_r;
        port_go_s         = 1'b0;
        case (port_state_r)
            PS_IDLE: begin
                if (port_req && port_hit_s) begin
                    port_go_s         = 1'b1;
                    port_state_next_s = PS_STB;
                end else begin
                    port_state_next_s = PS_IDLE;
                end
            end
            PS_STB: port_state_next_s = PS_HOLD;
            PS_HOLD: begin
                if (!port_req) port_state_next_s = PS_IDLE;
                else           port_state_next_s = PS_HOLD;
            end
            default: port_state_next_s = PS_IDLE;
        endcase
        port_wr_s = port_go_s && !zxb_rnw;
    end

    // Register read mux; unimplemented bits read as zero.
    always_comb begin
        port_rd_s = 8'd0;
        case (zaddr[1:0])
            OFF_PAGE:    port_rd_s = {3'd0, page_r};
            OFF_CTRL:    port_rd_s = {7'd0, ctrl_men_r};
            OFF_SCRATCH: port_rd_s = scratch_r;
            OFF_ACCNT:   port_rd_s = accnt_r;
            default:     port_rd_s = 8'd0;
        endcase
    end

    // Port FSM state and completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_state_r <= PS_IDLE;
            port_stb_r   <= 1'b0;
        end else begin
            port_state_r <= port_state_next_s;
            port_stb_r   <= (port_state_next_s == PS_STB);
        end
    end

    // Configuration registers and the completed-access counter (a clear beats a count).
    always_ff @(posedge clk) begin
        if (reset) begin
            page_r     <= 5'd0;
            ctrl_men_r <= 1'b0;
            scratch_r  <= 8'd0;
            accnt_r    <= 8'd0;
        end else begin
            if (port_wr_s && (zaddr[1:0] == OFF_PAGE))    page_r     <= zdata_in[PAGE_W-1:0];
            else                                          page_r     <= page_r;
            if (port_wr_s && (zaddr[1:0] == OFF_CTRL))    ctrl_men_r <= zdata_in[CTRL_MEN];
            else                                          ctrl_men_r <= ctrl_men_r;
            if (port_wr_s && (zaddr[1:0] == OFF_SCRATCH)) scratch_r  <= zdata_in;
            else                                          scratch_r  <= scratch_r;
            if (port_wr_s && (zaddr[1:0] == OFF_ACCNT))   accnt_r    <= 8'd0;
            else if (mem_stb)                             accnt_r    <= accnt_r + 8'd1;
            else                                          accnt_r    <= accnt_r;
        end
    end

    // Read data holds until either path completes a read.
    always_ff @(posedge clk) begin
        if (reset)                      rdata_r <= 8'd0;
        else if (port_go_s && zxb_rnw)  rdata_r <= port_rd_s;
        else if (mem_rd_done_s)         rdata_r <= sram_dq_i;
        else                            rdata_r <= rdata_r;
    end

    assign port_stb = port_stb_r;
    assign rdata    = rdata_r;

    zxb_sram_if #(
        .MEM_WAIT (MEM_WAIT)
    ) u_sram_if (
        .clk        (clk),
        .reset      (reset),
        .start      (mem_start_s),
        .mem_req    (mem_req),
        .rnw        (zxb_rnw),
        .wdata      (zdata_in),
        .addr       (sram_addr_f(page_r, zaddr[13:0])),
        .sram_dq_i  (sram_dq_i),
        .mem_stb    (mem_stb),
        .rd_done    (mem_rd_done_s),
        .sram_addr  (sram_addr),
        .sram_dq_o  (sram_dq_o),
        .sram_dq_oe (sram_dq_oe),
        .sram_cs_n  (sram_cs_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

endmodule
